// File: rtl/ldpc_pkg.sv
// ldpc_pkg -- constants shared by the LDPC encoder and syndrome checker.
//   N_DEF / K_DEF : default codeword / information lengths
//   M_DEF         : derived number of parity checks (N-K)
//   ldpc_state_e  : syndrome checker FSM encoding
//   cnt_width()   : row counter width, clog2(m) but never below 1
package ldpc_pkg;

  localparam int N_DEF = 11;
  localparam int K_DEF = 6;
  localparam int M_DEF = N_DEF - K_DEF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DONE    = 2'd2
  } ldpc_state_e;

  function automatic int cnt_width(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/row_parity.sv
// row_parity -- one parity check of H against a codeword.
//   row_i : one H row (N bits)
//   cw_i  : codeword (N bits)
//   par_o : XOR-reduce(row_i & cw_i)
module row_parity #(
  parameter int N = 11
) (
  input  logic [N-1:0] row_i,
  input  logic [N-1:0] cw_i,
  output logic         par_o
);

  assign par_o = ^(row_i & cw_i);

endmodule

// File: rtl/syndrome_check.sv
// syndrome_check -- serial syndrome computation, one H row per enabled cycle.
//   clk, rst        : clock, synchronous active-high reset
//   i_en            : clock enable, low freezes everything
//   i_valid         : codeword/parity_check valid (only looked at in IDLE)
//   codeword [N]    : received word, codeword[N-1] is column 0
//   parity_check    : flattened H, row r = parity_check[(M-r)*N-1 -: N]
//   i_ack           : downstream takes the result (only looked at in DONE)
//   o_ready         : high in IDLE
//   syndrome [M]    : row r result at syndrome[M-1-r]
//   o_valid, o_err  : result valid (DONE only), syndrome nonzero
module syndrome_check
  import ldpc_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int K = K_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_valid,
  input  logic [N-1:0]     codeword,
  input  logic [(N-K)*N-1:0] parity_check,
  input  logic             i_ack,
  output logic             o_ready,
  output logic [N-K-1:0]   syndrome,
  output logic             o_valid,
  output logic             o_err
);

  localparam int M  = N - K;
  localparam int CW = cnt_width(M);

  ldpc_state_e     state_q;
  logic [CW-1:0]   cnt_q;
  logic [N-1:0]    cw_q;
  logic [M*N-1:0]  h_q;
  logic [M-1:0]    syn_q;
  logic            valid_q, err_q, ready_q;

  logic [N-1:0]    row_sel;
  logic            row_bit;
  logic [M-1:0]    syn_d;

  // Row mux driven by the counter; one shared parity unit does every row.
  always_comb begin
    row_sel = '0;
    for (int r = 0; r < M; r++)
      if (cnt_q == CW'(r)) row_sel = h_q[(M-1-r)*N +: N];
  end

  row_parity #(.N(N)) u_row_parity (
    .row_i (row_sel),
    .cw_i  (cw_q),
    .par_o (row_bit)
  );

  // Syndrome with the current row folded in; also feeds o_err on the last row.
  always_comb begin
    syn_d = syn_q;
    for (int r = 0; r < M; r++)
      if (cnt_q == CW'(r)) syn_d[M-1-r] = row_bit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cw_q    <= '0;
      h_q     <= '0;
      syn_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
    end else if (i_en) begin
      case (state_q)
        ST_IDLE: begin
          if (i_valid) begin
            cw_q    <= codeword;
            h_q     <= parity_check;
            syn_q   <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            state_q <= ST_COMPUTE;
          end
        end
        ST_COMPUTE: begin
          syn_q <= syn_d;
          if (cnt_q == CW'(M-1)) begin
            valid_q <= 1'b1;
            err_q   <= |syn_d;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_DONE: begin
          if (i_ack) begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
          err_q   <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready  = ready_q;
  assign o_valid  = valid_q;
  assign o_err    = err_q;
  assign syndrome = syn_q;

endmodule

// File: tb/tb_syndrome_check.sv
module tb_syndrome_check;

  localparam int N = 11;
  localparam int K = 6;
  localparam int M = N - K;

  typedef struct {
    logic [M-1:0] syn;
    logic         err;
    int           lat;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst, i_en, i_valid, i_ack;
  logic [N-1:0]     codeword;
  logic [M*N-1:0]   parity_check;
  logic             o_ready, o_valid, o_err;
  logic [M-1:0]     syndrome;

  int nvec = 0;
  int nerr = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  syndrome_check #(.N(N), .K(K)) dut (
    .clk(clk), .rst(rst), .i_en(i_en), .i_valid(i_valid),
    .codeword(codeword), .parity_check(parity_check), .i_ack(i_ack),
    .o_ready(o_ready), .syndrome(syndrome), .o_valid(o_valid), .o_err(o_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference: count columns where both H and the codeword hold a 1, take parity.
  function automatic logic [M-1:0] model(input logic [M*N-1:0] h, input logic [N-1:0] cw);
    logic [M-1:0] s;
    s = '0;
    for (int r = 0; r < M; r++) begin
      int ones = 0;
      for (int c = 0; c < N; c++)
        if (h[(M-r)*N-1-c] && cw[N-1-c]) ones++;
      s[M-1-r] = (ones % 2 == 1);
    end
    return s;
  endfunction

  function automatic logic [M*N-1:0] h_ident();
    logic [M*N-1:0] h;
    h = '0;
    for (int r = 0; r < M; r++) h[(M-r)*N-1-r] = 1'b1;
    return h;
  endfunction

  // Monitor: times each accepted word and scores the result when o_valid rises.
  bit pend = 0;
  int cyc = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) pend <= 0;
    else if (i_en && i_valid && o_ready) begin
      pend <= 1;
      cyc  <= 0;
    end
  end

  always @(negedge clk) begin
    if (pend) cyc = cyc + 1;
    if (o_valid && !prev_valid) begin
      if (!pend || sb.size() == 0) begin
        check("unexpected_valid", 32'(o_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("syndrome", 32'(syndrome), 32'(e.syn));
        check("o_err", 32'(o_err), 32'(e.err));
        check("latency", 32'(cyc), 32'(e.lat));
        pend = 0;
      end
    end
    prev_valid = o_valid;
  end

  // Issue one word; 'gaps' enable-low cycles are sprinkled before the last row.
  task automatic issue(input logic [M*N-1:0] h, input logic [N-1:0] cw,
                       input int gaps, input bit scramble);
    exp_t e;
    int ones = 0;
    int g = gaps;
    e.syn = model(h, cw);
    e.err = |e.syn;
    e.lat = M + 1 + gaps;
    @(negedge clk);
    parity_check = h; codeword = cw; i_valid = 1'b1; i_en = 1'b1; i_ack = 1'b0;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    while (ones < M) begin
      check("busy_ready", 32'(o_ready), 32'd0);
      if (g > 0 && ($urandom_range(1) == 1 || ones == M-1)) begin
        i_en = 1'b0; g--;
      end else begin
        i_en = 1'b1; ones++;
      end
      if (scramble) begin
        for (int i = 0; i < M*N; i++) parity_check[i] = 1'($urandom_range(1));
        codeword = N'($urandom);
        i_valid  = 1'($urandom_range(1));
        i_ack    = 1'($urandom_range(1));
      end
      @(negedge clk);
    end
    i_en = 1'b1; i_valid = 1'b0; i_ack = 1'b0;
  endtask

  // Hold the result for 'hold' cycles, then acknowledge and check the return to IDLE.
  task automatic finish_word(input logic [M-1:0] exp_syn, input int hold);
    int t = 0;
    while (!o_valid && t < 50) begin
      @(negedge clk); t++;
    end
    check("done_timeout", 32'(o_valid), 32'd1);
    for (int i = 0; i < hold; i++) begin
      i_ack = (i == hold/2);   // ack with enable low must be ignored
      i_en  = (i != hold/2);
      @(negedge clk);
      check("hold_valid", 32'(o_valid), 32'd1);
      check("hold_syn", 32'(syndrome), 32'(exp_syn));
    end
    i_en = 1'b1; i_ack = 1'b1;
    @(negedge clk);
    i_ack = 1'b0;
    check("ack_ready", 32'(o_ready), 32'd1);
    check("ack_valid", 32'(o_valid), 32'd0);
    check("ack_err", 32'(o_err), 32'd0);
  endtask

  initial begin
    logic [M*N-1:0] h;
    logic [N-1:0]   cw;
    rst = 1'b1; i_en = 1'b0; i_valid = 1'b0; i_ack = 1'b0;
    codeword = '0; parity_check = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_err", 32'(o_err), 32'd0);
    check("rst_syn", 32'(syndrome), 32'd0);
    rst = 1'b0;

    // Identity H, zero word.
    issue(h_ident(), 11'b00000_000000, 0, 0);
    finish_word(5'b00000, 2);

    // Identity H, nonzero word, long hold.
    issue(h_ident(), 11'b10110_000000, 0, 0);
    finish_word(5'b10110, 10);

    // Inputs scrambled and i_valid/i_ack toggled during COMPUTE.
    issue(h_ident(), 11'b01101_101010, 0, 1);
    finish_word(model(h_ident(), 11'b01101_101010), 3);

    // Three enable-low cycles: result appears at cycle 9.
    issue(h_ident(), 11'b11001_000111, 3, 0);
    finish_word(5'b11001, 2);

    // Reset three cycles into COMPUTE aborts the word.
    @(negedge clk);
    parity_check = h_ident(); codeword = 11'b11111_000000; i_valid = 1'b1; i_en = 1'b1;
    @(posedge clk);
    @(negedge clk); i_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("abort_ready", 32'(o_ready), 32'd1);
    check("abort_valid", 32'(o_valid), 32'd0);
    check("abort_syn", 32'(syndrome), 32'd0);
    check("abort_err", 32'(o_err), 32'd0);
    repeat (8) begin
      @(negedge clk);
      check("abort_no_valid", 32'(o_valid), 32'd0);
    end

    // All-ones H and word.
    issue({(M*N){1'b1}}, {N{1'b1}}, 0, 0);
    finish_word(5'b11111, 2);

    // Random words with random enable gaps.
    for (int k = 0; k < 25; k++) begin
      for (int i = 0; i < M*N; i++) h[i] = 1'($urandom_range(1));
      cw = N'($urandom);
      issue(h, cw, $urandom_range(4), 1'($urandom_range(1)));
      finish_word(model(h, cw), $urandom_range(1, 4));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
